wallace_product_acc: RTL and testbench
======================================

# wallace_product_acc

Sequential accumulator that sits directly downstream of the 32x32 Wallace multiplier (`wallace_32`). It consumes a stream of 64-bit unsigned products under a valid/ready handshake and sums a programmed number of them into a guard-extended accumulator. It returns the total through a second valid/ready handshake and flags any overflow. Together with the multiplier it forms a dot-product / MAC datapath.

## Interface
Parameters:
- `PW`, default 64: product width; must match the multiplier output `P`.
- `GW`, default 16: guard bits; accumulator width is `AW = PW+GW`.
- `LW`, default 16: width of the length field.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: begin a new accumulation; honoured only in IDLE.
- `len`, input, LW: number of products to sum; sampled when `start` is accepted.
- `p_valid`, input, 1: upstream product valid.
- `p_ready`, output, 1: block can accept a product.
- `p_data`, input, PW: unsigned product from the multiplier.
- `acc_valid`, output, 1: result available.
- `acc_ready`, input, 1: downstream accepts the result.
- `acc_data`, output, AW: accumulated sum.
- `acc_ovf`, output, 1: sticky overflow flag for the current job; qualified by `acc_valid`.
- `busy`, output, 1: high in any state other than IDLE.
- `remaining`, output, LW: products still to be accepted in the current job.

## Operation
- FSM states are IDLE, ACCUM and HOLD.
- IDLE:
  - `p_ready`=0, `acc_valid`=0.
  - When `start`=1: `acc`←0, `ovf`←0, `remaining`←`len`.
  - If `len`=0 the next state is HOLD (result 0, no products consumed); otherwise the next state is ACCUM.
- ACCUM:
  - `p_ready`=1. A product transfers when `p_valid && p_ready`.
  - On each transfer: `acc`←(`acc` + zero-extended `p_data`) mod 2^AW, and `remaining`←`remaining`−1.
  - `ovf` is set if the addition carries out of bit AW−1. Once set, it stays set until the next accepted `start`.
  - When `remaining`=1 and a transfer occurs, the next state is HOLD.
  - `p_valid`=0 cycles are stalls: no state change and no timeout.
- HOLD:
  - `acc_valid`=1, `acc_data`=`acc`, `acc_ovf`=`ovf`, `p_ready`=0.
  - `acc_data` and `acc_ovf` stay stable while `acc_valid`=1 and `acc_ready`=0.
  - When `acc_ready`=1 the next state is IDLE. `acc_data` keeps its last value after the handshake.
- `start` outside IDLE is ignored, not queued.
- Arithmetic is unsigned only. With GW=16, up to 65536 full-scale products are summed without overflow; the flag covers larger `len` or a reduced GW.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) forces: state=IDLE, `p_ready`=0, `acc_valid`=0, `acc_data`=0, `acc_ovf`=0, `busy`=0, `remaining`=0.
- Reset asserted mid-job aborts immediately: partial sum discarded, no result emitted.
- `p_ready` is a registered state decode. It does not depend combinationally on `p_valid`.
- Start to ready: `start` accepted at edge N gives `p_ready`=1 from cycle N+1.
- Last product to result: the last product accepted at edge M gives `acc_valid`=1 in cycle M+1.
  - At full throughput, `len`=K completes in K+1 cycles after `start`, plus the result handshake.
- `len`=0: `acc_valid`=1 one cycle after `start`, with `acc_data`=0 and `acc_ovf`=0.
- Result handshake:
  - If `acc_ready` is already high when HOLD is entered, the result transfers in that first HOLD cycle and IDLE follows.
  - A new `start` is accepted in the cycle after the result handshake at the earliest.
- A new `start` in the same cycle as `acc_ready` in HOLD is ignored.
- Back-to-back products, one per cycle, must be supported with no bubbles.

## Test plan
- Basic: reset; `start`, `len`=3; products 5, 7, 9 sent back-to-back; `acc_ready`=1 → `acc_valid` one cycle after the third transfer, `acc_data`=21, `acc_ovf`=0, `busy` falls the following cycle.
- Stalls and backpressure: `len`=4; product 0xFFFF_FFFE_0000_0001 (=(2^32−1)^2) sent four times with random `p_valid` gaps; hold `acc_ready`=0 for 5 cycles → `acc_data`=4×0xFFFF_FFFE_0000_0001 stable throughout HOLD; `remaining` steps 4,3,2,1,0.
- Zero length: `start` with `len`=0 → `p_ready` never asserts; `acc_valid` next cycle with `acc_data`=0.
- Overflow: GW=0 build, `len`=2; products 2^64−1 and 2 → `acc_data`=1, `acc_ovf`=1. The next job with `len`=1 and product 3 → `acc_data`=3, `acc_ovf`=0.
- Abort and ignored start: `len`=5; assert `rst_n`=0 after 2 products → all outputs at reset values within the same cycle; after release a new `len`=1 job with product 10 returns 10. Pulsing `start` during ACCUM has no effect on `remaining`.
- End-to-end: drive `wallace_32` from random 32-bit operand pairs into the block, `len`=100 → `acc_data` equals the reference sum of the 100 products.

Source files
------------

// File: rtl/wallace_product_acc.sv
// wallace_product_acc: sums a programmed number of unsigned multiplier products
// into a guard-extended accumulator, with valid/ready on both sides and a sticky overflow flag.
module wallace_product_acc #(
    parameter int PW = 64,
    parameter int GW = 16,
    parameter int LW = 16,
    localparam int AW = PW + GW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          p_valid,
    output logic          p_ready,
    input  logic [PW-1:0] p_data,
    output logic          acc_valid,
    input  logic          acc_ready,
    output logic [AW-1:0] acc_data,
    output logic          acc_ovf,
    output logic          busy,
    output logic [LW-1:0] remaining
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] acc;
    logic          ovf;
    logic [LW-1:0] rem;
    logic [AW:0]   sum;
    logic          xfer;
    logic          take;

    assign take = (state == IDLE) && start;
    assign xfer = (state == ACCUM) && p_valid;
    // One spare bit on the adder captures the carry out of the accumulator.
    assign sum  = {1'b0, acc} + (AW+1)'(p_data);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        if (take)                                 state_nxt = (len == '0) ? HOLD : ACCUM;
        else if (xfer && rem == LW'(1))           state_nxt = HOLD;
        else if (state == HOLD && acc_ready)      state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
            rem <= '0;
        end else if (take) begin
            acc <= '0;
            ovf <= 1'b0;
            rem <= len;
        end else if (xfer) begin
            acc <= sum[AW-1:0];
            ovf <= ovf | sum[AW];
            rem <= rem - LW'(1);
        end

    assign p_ready   = state == ACCUM;
    assign acc_valid = state == HOLD;
    assign busy      = state != IDLE;
    assign acc_data  = acc;
    assign acc_ovf   = ovf;
    assign remaining = rem;
endmodule

// File: tb/tb_wallace_product_acc.sv
// tb_wallace_product_acc: randomized scoreboard bench; a GW=16 and a GW=0 instance
// share the product bus, and each has its own expected-result queue and monitor.
module tb_wallace_product_acc;
    typedef struct {
        logic [79:0] d;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, start, sel, p_valid, acc_ready;
    logic [15:0] len;
    logic [63:0] p_data;
    logic        start16, start0;

    logic        p_ready16, acc_valid16, acc_ovf16, busy16;
    logic [79:0] acc_data16;
    logic [15:0] remaining16;
    logic        p_ready0, acc_valid0, acc_ovf0, busy0;
    logic [63:0] acc_data0;
    logic [15:0] remaining0;

    exp_t        q16[$], q0[$];
    logic [63:0] prods[$];
    int          tests = 0, fails = 0, rdy_pct = 100;

    always #5 clk = ~clk;

    assign start16 = start & ~sel;
    assign start0  = start & sel;

    wallace_product_acc u_dut (
        .clk(clk), .rst_n(rst_n), .start(start16), .len(len),
        .p_valid(p_valid), .p_ready(p_ready16), .p_data(p_data),
        .acc_valid(acc_valid16), .acc_ready(acc_ready), .acc_data(acc_data16),
        .acc_ovf(acc_ovf16), .busy(busy16), .remaining(remaining16)
    );

    wallace_product_acc #(.GW(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .len(len),
        .p_valid(p_valid), .p_ready(p_ready0), .p_data(p_data),
        .acc_valid(acc_valid0), .acc_ready(acc_ready), .acc_data(acc_data0),
        .acc_ovf(acc_ovf0), .busy(busy0), .remaining(remaining0)
    );

    task automatic chk(input string n, input logic [79:0] a, input logic [79:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic timeout(input string n);
        tests++;
        fails++;
        $display("FAIL %s timed out at %0t", n, $time);
    endtask

    initial forever begin
        @(posedge clk);
        #1 acc_ready = $urandom_range(99) < rdy_pct;
    end

    always @(negedge clk)
        if (rst_n && acc_valid16) begin
            if (q16.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result16 got %0h expected none", acc_data16);
            end else begin
                chk("acc_data16", acc_data16, q16[0].d);
                chk("acc_ovf16", 80'(acc_ovf16), 80'(q16[0].o));
                if (acc_ready) void'(q16.pop_front());
            end
        end

    always @(negedge clk)
        if (rst_n && acc_valid0) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result0 got %0h expected none", acc_data0);
            end else begin
                chk("acc_data0", 80'(acc_data0), q0[0].d);
                chk("acc_ovf0", 80'(acc_ovf0), 80'(q0[0].o));
                if (acc_ready) void'(q0.pop_front());
            end
        end

    // Runs one job over prods on the selected instance; the reference result is the
    // plain wide sum of the products, truncated to that instance's accumulator width.
    task automatic job(input logic s, input int gap, input int abort_at, input logic poke);
        int          n = prods.size();
        int          t = 0;
        logic [95:0] tot = '0;
        exp_t        e;
        foreach (prods[i]) tot += 96'(prods[i]);
        e.d = s ? {16'b0, tot[63:0]} : tot[79:0];
        e.o = s ? (tot[95:64] != '0) : (tot[95:80] != '0);
        forever begin
            @(negedge clk);
            if (!busy16 && !busy0) break;
            if (++t > 500) begin timeout("idle_wait"); break; end
        end
        sel   = s;
        start = 1'b1;
        len   = 16'(n);
        if (s) q0.push_back(e); else q16.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("p_ready_after_start", 80'(s ? p_ready0 : p_ready16), 80'(n != 0));
        chk("valid_after_start", 80'(s ? acc_valid0 : acc_valid16), 80'(n == 0));
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            if (i == abort_at) begin
                rst_n = 1'b0;
                p_valid = 1'b0;
                #1;
                chk("abort_p_ready", 80'(p_ready16), 80'(0));
                chk("abort_acc_valid", 80'(acc_valid16), 80'(0));
                chk("abort_acc_data", acc_data16, 80'(0));
                chk("abort_acc_ovf", 80'(acc_ovf16), 80'(0));
                chk("abort_busy", 80'(busy16), 80'(0));
                chk("abort_remaining", 80'(remaining16), 80'(0));
                if (s) void'(q0.pop_back()); else void'(q16.pop_back());
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            while (gap > 0 && $urandom_range(99) < gap) begin
                p_valid = 1'b0;
                @(negedge clk);
            end
            chk("remaining", 80'(s ? remaining0 : remaining16), 80'(n - i));
            chk("p_ready", 80'(s ? p_ready0 : p_ready16), 80'(1));
            if (poke && i == 2) begin
                start = 1'b1;
                len   = 16'd7;
            end
            p_valid = 1'b1;
            p_data  = prods[i];
            @(negedge clk);
        end
        p_valid = 1'b0;
        start   = 1'b0;
        if (n > 0) begin
            chk("valid_after_last", 80'(s ? acc_valid0 : acc_valid16), 80'(1));
            chk("remaining_done", 80'(s ? remaining0 : remaining16), 80'(0));
        end
    endtask

    initial begin
        int t = 0;
        rst_n = 1'b0; start = 1'b0; sel = 1'b0; p_valid = 1'b0;
        len = '0; p_data = '0; acc_ready = 1'b1;
        #12;
        chk("rst_p_ready", 80'(p_ready16), 80'(0));
        chk("rst_acc_valid", 80'(acc_valid16), 80'(0));
        chk("rst_acc_data", acc_data16, 80'(0));
        chk("rst_busy", 80'(busy16), 80'(0));
        chk("rst_remaining", 80'(remaining16), 80'(0));
        @(negedge clk);
        rst_n = 1'b1;

        prods = '{64'd5, 64'd7, 64'd9};
        job(1'b0, 0, -1, 1'b0);

        rdy_pct = 0;
        prods = '{4{64'hFFFF_FFFE_0000_0001}};
        job(1'b0, 50, -1, 1'b0);
        repeat (5) @(negedge clk);
        rdy_pct = 100;

        prods.delete();
        job(1'b0, 0, -1, 1'b0);

        prods = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
        job(1'b1, 0, -1, 1'b0);
        prods = '{64'd3};
        job(1'b1, 0, -1, 1'b0);

        prods = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
        job(1'b0, 0, 2, 1'b0);
        prods = '{64'd10};
        job(1'b0, 0, -1, 1'b0);

        prods = '{64'd11, 64'd22, 64'd33, 64'd44, 64'd55};
        job(1'b0, 0, -1, 1'b1);

        rdy_pct = 60;
        prods.delete();
        for (int i = 0; i < 100; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            prods.push_back(64'(a) * 64'(b));
        end
        job(1'b0, 30, -1, 1'b0);

        for (int j = 0; j < 4; j++) begin
            prods.delete();
            for (int i = 0; i < int'($urandom_range(8, 1)); i++)
                prods.push_back({$urandom, $urandom});
            job(1'b1, 20, -1, 1'b0);
        end

        rdy_pct = 100;
        while (busy16 || busy0 || q16.size() != 0 || q0.size() != 0) begin
            @(negedge clk);
            if (++t > 2000) begin timeout("drain"); break; end
        end
        chk("q16_empty", 80'(q16.size()), 80'(0));
        chk("q0_empty", 80'(q0.size()), 80'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
